gpr_wr_arb: RTL and testbench

GPR_WR_ARB -- requirements
Module: gpr_wr_arb

---
 rtl/gpr_wr_arb.sv | 139 +++++++++++++
 tb/tb_gpr_wr_arb.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gpr_wr_arb.sv
// Two-slot register-file writeback arbiter with same-register ordering and hazard lookup.
// Define GPR_WR_ARB_RR_EN for round-robin contention; the default is fixed priority to slot 0.
module gpr_wr_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [4:0]  req0_addr,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req0_data,
  input  logic [31:0] req1_data,
  output logic        gpr_we_,
  output logic [4:0]  gpr_wr_addr,
  output logic [31:0] gpr_wr_data,
  output logic        grant_id,
  input  logic [4:0]  chk_addr_0,
  input  logic [4:0]  chk_addr_1,
  output logic        chk_busy_0,
  output logic        chk_busy_1
);

  logic        full0_q, full0_d, full1_q, full1_d;
  logic [4:0]  addr0_q, addr0_d, addr1_q, addr1_d;
  logic [31:0] data0_q, data0_d, data1_q, data1_d;
  logic        old1_q, old1_d;
  logic        sel_s, any_full_s, drain0_s, drain1_s, load0_s, load1_s;
`ifdef GPR_WR_ARB_RR_EN
  logic        rr_ptr_q, rr_ptr_d;
  logic        contend_s;
`endif

  // Slot selection uses only registered state so the write port has no input path.
  always_comb begin
    sel_s = 1'b0;
`ifdef GPR_WR_ARB_RR_EN
    contend_s = 1'b0;
`endif
    if (full0_q && full1_q) begin
      if (addr0_q == addr1_q) begin
        sel_s = old1_q;
      end else begin
`ifdef GPR_WR_ARB_RR_EN
        contend_s = 1'b1;
        sel_s     = rr_ptr_q;
`else
        sel_s     = 1'b0;
`endif
      end
    end else if (full1_q) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  assign any_full_s  = full0_q | full1_q;
  assign drain0_s    = any_full_s & ~sel_s;
  assign drain1_s    = any_full_s & sel_s;
  assign req0_ready  = ~full0_q | drain0_s;
  assign req1_ready  = ~full1_q | drain1_s;
  // Writes to x0 are acknowledged but never occupy a slot.
  assign load0_s     = req0_valid & req0_ready & (req0_addr != 5'd0);
  assign load1_s     = req1_valid & req1_ready & (req1_addr != 5'd0);

  assign gpr_we_     = ~any_full_s;
  assign grant_id    = sel_s;
  assign gpr_wr_addr = sel_s ? addr1_q : addr0_q;
  assign gpr_wr_data = sel_s ? data1_q : data0_q;

  assign chk_busy_0  = (chk_addr_0 != 5'd0) &
                       ((full0_q & (addr0_q == chk_addr_0)) | (full1_q & (addr1_q == chk_addr_0)));
  assign chk_busy_1  = (chk_addr_1 != 5'd0) &
                       ((full0_q & (addr0_q == chk_addr_1)) | (full1_q & (addr1_q == chk_addr_1)));

  // Slot, age and pointer next-state.
  always_comb begin
    full0_d = full0_q & ~drain0_s;
    full1_d = full1_q & ~drain1_s;
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    data0_d = data0_q;
    data1_d = data1_q;
    old1_d  = old1_q;
    if (load0_s) begin
      full0_d = 1'b1;
      addr0_d = req0_addr;
      data0_d = req0_data;
    end else begin
      full0_d = full0_d;
    end
    if (load1_s) begin
      full1_d = 1'b1;
      addr1_d = req1_addr;
      data1_d = req1_data;
    end else begin
      full1_d = full1_d;
    end
    // The slot loaded alone becomes the younger one; a joint load makes slot 0 older.
    if (load1_s) begin
      old1_d = 1'b0;
    end else if (load0_s) begin
      old1_d = 1'b1;
    end else begin
      old1_d = old1_q;
    end
`ifdef GPR_WR_ARB_RR_EN
    rr_ptr_d = contend_s ? ~rr_ptr_q : rr_ptr_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full0_q  <= 1'b0;
      full1_q  <= 1'b0;
      addr0_q  <= 5'd0;
      addr1_q  <= 5'd0;
      data0_q  <= 32'd0;
      data1_q  <= 32'd0;
      old1_q   <= 1'b0;
`ifdef GPR_WR_ARB_RR_EN
      rr_ptr_q <= 1'b0;
`endif
    end else begin
      full0_q  <= full0_d;
      full1_q  <= full1_d;
      addr0_q  <= addr0_d;
      addr1_q  <= addr1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      old1_q   <= old1_d;
`ifdef GPR_WR_ARB_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_gpr_wr_arb.sv
// Directed bench for gpr_wr_arb; expectations follow GPR_WR_ARB_RR_EN when defined.
module tb_gpr_wr_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr, gpr_wr_addr, chk_addr_0, chk_addr_1;
  logic [31:0] req0_data, req1_data, gpr_wr_data;
  logic        gpr_we_, grant_id, chk_busy_0, chk_busy_1;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        rr_first;

  gpr_wr_arb dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_data(req0_data), .req1_data(req1_data),
    .gpr_we_(gpr_we_), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data),
    .grant_id(grant_id),
    .chk_addr_0(chk_addr_0), .chk_addr_1(chk_addr_1),
    .chk_busy_0(chk_busy_0), .chk_busy_1(chk_busy_1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [4:0] a, input logic [31:0] d, input logic g);
    check_eq({tag, "_we"}, {31'd0, gpr_we_}, 32'd0);
    check_eq({tag, "_addr"}, {27'd0, gpr_wr_addr}, {27'd0, a});
    check_eq({tag, "_data"}, gpr_wr_data, d);
    check_eq({tag, "_gid"}, {31'd0, grant_id}, {31'd0, g});
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_we_idle"}, {31'd0, gpr_we_}, 32'd1);
  endtask

  initial begin
`ifdef GPR_WR_ARB_RR_EN
    rr_first = 1'b1;
`else
    rr_first = 1'b0;
`endif
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = 5'd0; req1_addr = 5'd0;
    req0_data = 32'd0; req1_data = 32'd0;
    chk_addr_0 = 5'd5; chk_addr_1 = 5'd0;
    step();
    step();
    check_eq("rst_we", {31'd0, gpr_we_}, 32'd1);
    check_eq("rst_addr", {27'd0, gpr_wr_addr}, 32'd0);
    check_eq("rst_data", gpr_wr_data, 32'd0);
    check_eq("rst_gid", {31'd0, grant_id}, 32'd0);
    check_eq("rst_busy0", {31'd0, chk_busy_0}, 32'd0);
    reset = 1'b0;
    check_eq("post_rst_rdy0", {31'd0, req0_ready}, 32'd1);
    check_eq("post_rst_rdy1", {31'd0, req1_ready}, 32'd1);

    // single uncontended write, one-cycle latency
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h0000_1234;
    step();
    req0_valid = 1'b0;
    check_wr("single", 5'd5, 32'h0000_1234, 1'b0);
    step();
    check_idle("single_after");

    // different-address contention, twice
    for (int r = 0; r < 2; r++) begin
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
      req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      if (r == 1 && rr_first) begin
        check_wr("cont_a", 5'd4, 32'h44, 1'b1);
        step();
        check_wr("cont_b", 5'd3, 32'h33, 1'b0);
      end else begin
        check_wr("cont_a", 5'd3, 32'h33, 1'b0);
        check_eq("cont_rdy1_blocked", {31'd0, req1_ready}, 32'd0);
        step();
        check_wr("cont_b", 5'd4, 32'h44, 1'b1);
      end
      step();
      check_idle("cont_after");
    end

    // same register from both requesters in sequence
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hA;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hB;
    check_wr("order_a", 5'd7, 32'hA, 1'b0);
    check_eq("order_rdy1", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    check_wr("order_b", 5'd7, 32'hB, 1'b1);
    step();
    check_idle("order_after");

    // both full on one register with slot 1 older: slot 1 must go first
    req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'h2;
    req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'hD;
    step();
    req1_valid = 1'b0;
    check_wr("age_a", 5'd2, 32'h2, 1'b0);
    req0_addr = 5'd8; req0_data = 32'hC;
    check_eq("age_rdy0", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    check_wr("age_b", 5'd8, 32'hD, 1'b1);
    step();
    check_wr("age_c", 5'd8, 32'hC, 1'b0);
    step();
    check_idle("age_after");

    // write to x0 is accepted and dropped
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_FFFF;
    check_eq("x0_rdy1", {31'd0, req1_ready}, 32'd1);
    step();
    req1_valid = 1'b0;
    check_idle("x0");

    // hazard lookup
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h9;
    step();
    req1_valid = 1'b0;
    chk_addr_0 = 5'd9; chk_addr_1 = 5'd0;
    #1;
    check_eq("busy0_hit", {31'd0, chk_busy_0}, 32'd1);
    check_eq("busy1_zero", {31'd0, chk_busy_1}, 32'd0);
    chk_addr_1 = 5'd6;
    #1;
    check_eq("busy1_miss", {31'd0, chk_busy_1}, 32'd0);
    step();
    check_eq("busy0_cleared", {31'd0, chk_busy_0}, 32'd0);

    // reset while both slots are full
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'h10;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'h11;
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk_addr_0 = 5'd10; chk_addr_1 = 5'd11;
    #1;
    check_eq("pre_rst_we", {31'd0, gpr_we_}, 32'd0);
    check_eq("pre_rst_busy1", {31'd0, chk_busy_1}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_we", {31'd0, gpr_we_}, 32'd1);
    check_eq("mid_rst_busy0", {31'd0, chk_busy_0}, 32'd0);
    check_eq("mid_rst_busy1", {31'd0, chk_busy_1}, 32'd0);
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_idle("after_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
